reg_file_2r1w: RTL and testbench

- Parametrised register file built from per-bit enable/reset flip-flop storage; the next generation of the team's single-bit enabled DFF.
- One write port with per-byte write enables; two independent read ports with registered outputs and a read-valid flag.
- Optional write-to-read bypass.
- Sits between the datapath ALU/shifter and the control FSM as general-purpose architectural register storage.

---
 rtl/reg_file_2r1w.sv | 172 +++++++++++++++++
 tb/tb_reg_file_2r1w.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_2r1w
// Purpose  : General-purpose architectural register file. One write port
//            with per-byte enables, two independent registered read ports
//            with read-valid flags, optional write-to-read bypass and an
//            optional hardwired-zero register 0. Storage is built from
//            per-bit enable/reset flip-flops that hold when not enabled.
// Ports    : clk_i      - clock, all state updates on the rising edge
//            reset_i    - synchronous active-high reset
//            we_i       - write enable
//            waddr_i    - write address [AW-1:0]
//            wdata_i    - write data [WIDTH-1:0]
//            wbe_i      - byte enables [WIDTH/8-1:0], bit i gates byte i
//            re0_i      - read-port-0 request
//            raddr0_i   - read-port-0 address [AW-1:0]
//            rdata0_o   - read-port-0 data (registered)
//            rvalid0_o  - rdata0_o holds a fresh result this cycle
//            re1_i      - read-port-1 request
//            raddr1_i   - read-port-1 address [AW-1:0]
//            rdata1_o   - read-port-1 data (registered)
//            rvalid1_o  - rdata1_o holds a fresh result this cycle
//            werr_o     - one-cycle pulse after a write to an address >= DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_2r1w #(
  parameter int WIDTH     = 32,   // multiple of 8
  parameter int DEPTH     = 8,    // >= 2
  parameter int AW        = 3,    // DEPTH <= 2**AW
  parameter bit BYPASS    = 1'b1,
  parameter bit ZERO_REG0 = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic [WIDTH/8-1:0] wbe_i,
  input  logic               re0_i,
  input  logic [AW-1:0]      raddr0_i,
  output logic [WIDTH-1:0]   rdata0_o,
  output logic               rvalid0_o,
  input  logic               re1_i,
  input  logic [AW-1:0]      raddr1_i,
  output logic [WIDTH-1:0]   rdata1_o,
  output logic               rvalid1_o,
  output logic               werr_o
);

  localparam int NBYTES = WIDTH / 8;
  // The decoded address space covers every encodable address so that an
  // out-of-range read simply indexes an all-zero slot.
  localparam int NSLOTS = 2 ** AW;
  // One extra bit so that DEPTH == 2**AW is representable.
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  // --------------------------------------------------------------------------
  // Write decode
  // --------------------------------------------------------------------------
  logic             wr_in_range;
  logic             wr_drop_zero;
  logic             wr_go;
  logic [WIDTH-1:0] wmask;

  assign wr_in_range  = ({1'b0, waddr_i} < DEPTH_LIM);
  assign wr_drop_zero = ZERO_REG0 && (waddr_i == '0);
  assign wr_go        = we_i && wr_in_range && !wr_drop_zero;

  // Byte enables expanded to a per-bit mask; shared by storage and bypass.
  always_comb begin
    wmask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      wmask[8*i +: 8] = {8{wbe_i[i]}};
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] rf [NSLOTS];

  for (genvar r = 0; r < NSLOTS; r++) begin : g_slot
    if (r >= DEPTH) begin : g_unused
      assign rf[r] = '0;
    end else if (ZERO_REG0 && (r == 0)) begin : g_zero
      assign rf[r] = '0;
    end else begin : g_store
      logic             sel;
      logic [WIDTH-1:0] bit_en;

      assign sel    = wr_go && (waddr_i == AW'(r));
      assign bit_en = {WIDTH{sel}} & wmask;

      // Per-bit enable/reset flip-flop: clears on reset, loads when
      // enabled, otherwise holds.
      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic bit_q;

        always_ff @(posedge clk_i) begin
          if (reset_i) begin
            bit_q <= 1'b0;
          end else if (bit_en[b]) begin
            bit_q <= wdata_i[b];
          end
        end

        assign rf[r][b] = bit_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < 2; p++) begin : g_rport
    logic             re;
    logic [AW-1:0]    raddr;
    logic             bypass_hit;
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    assign re    = (p == 0) ? re0_i    : re1_i;
    assign raddr = (p == 0) ? raddr0_i : raddr1_i;

    // wr_go already excludes out-of-range and dropped zero-register writes,
    // so a hit can only occur on a slot that really changes this cycle.
    assign bypass_hit = BYPASS && wr_go && (waddr_i == raddr);

    always_comb begin
      rdata_d = rf[raddr];
      if (bypass_hit) begin
        rdata_d = (rf[raddr] & ~wmask) | (wdata_i & wmask);
      end
    end

    // rdata holds when no read is requested; only rvalid drops.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= re;
        if (re) begin
          rdata_q <= rdata_d;
        end
      end
    end
  end

  assign rdata0_o  = g_rport[0].rdata_q;
  assign rvalid0_o = g_rport[0].rvalid_q;
  assign rdata1_o  = g_rport[1].rdata_q;
  assign rvalid1_o = g_rport[1].rvalid_q;

  // --------------------------------------------------------------------------
  // Write error flag
  // --------------------------------------------------------------------------
  logic werr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      werr_q <= 1'b0;
    end else begin
      werr_q <= we_i && !wr_in_range;
    end
  end

  assign werr_o = werr_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_2r1w
// Purpose  : Self-checking bench for reg_file_2r1w. Two instances share one
//            stimulus stream: A uses the defaults (DEPTH 8, bypass on), B uses
//            DEPTH 6, bypass off and a hardwired-zero register 0. Directed
//            steps are followed by random traffic checked against a
//            behavioural model of the register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        re0, re1;
  logic [2:0]  raddr0, raddr1;

  logic [31:0] rdata0_a, rdata1_a, rdata0_b, rdata1_b;
  logic        rvalid0_a, rvalid1_a, rvalid0_b, rvalid1_b;
  logic        werr_a, werr_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file_2r1w #(.WIDTH(32), .DEPTH(8), .AW(3), .BYPASS(1'b1), .ZERO_REG0(1'b0)) dut_a (
    .clk_i(clk), .reset_i(reset), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
    .re0_i(re0), .raddr0_i(raddr0), .rdata0_o(rdata0_a), .rvalid0_o(rvalid0_a),
    .re1_i(re1), .raddr1_i(raddr1), .rdata1_o(rdata1_a), .rvalid1_o(rvalid1_a),
    .werr_o(werr_a)
  );

  reg_file_2r1w #(.WIDTH(32), .DEPTH(6), .AW(3), .BYPASS(1'b0), .ZERO_REG0(1'b1)) dut_b (
    .clk_i(clk), .reset_i(reset), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
    .re0_i(re0), .raddr0_i(raddr0), .rdata0_o(rdata0_b), .rvalid0_o(rvalid0_b),
    .re1_i(re1), .raddr1_i(raddr1), .rdata1_o(rdata1_b), .rvalid1_o(rvalid1_b),
    .werr_o(werr_b)
  );

  // Reference model: index 0 = instance A, index 1 = instance B.
  int          p_depth [2] = '{8, 6};
  bit          p_byp   [2] = '{1'b1, 1'b0};
  bit          p_z0    [2] = '{1'b0, 1'b1};
  logic [31:0] m_mem   [2][8];
  logic [31:0] e_rd    [2][2];
  logic        e_rv    [2][2];
  logic        e_werr  [2];

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  function automatic bit write_lands(input int d);
    return we && (int'(waddr) < p_depth[d]) && !(p_z0[d] && waddr == 3'd0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
    re0 = 1'b0; re1 = 1'b0; raddr0 = '0; raddr1 = '0;
  endtask

  // Advance one clock: predict outputs from the current inputs and model
  // state, let the edge happen, compare, then commit the model write.
  task automatic tick();
    logic        re_p;
    logic [2:0]  ra;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        re_p = (p == 0) ? re0 : re1;
        ra   = (p == 0) ? raddr0 : raddr1;
        if (reset) begin
          e_rd[d][p] = '0;
          e_rv[d][p] = 1'b0;
        end else if (re_p) begin
          e_rv[d][p] = 1'b1;
          if (int'(ra) >= p_depth[d])
            e_rd[d][p] = '0;
          else if (p_byp[d] && write_lands(d) && waddr == ra)
            e_rd[d][p] = merge(m_mem[d][ra], wdata, wbe);
          else
            e_rd[d][p] = m_mem[d][ra];
        end else begin
          e_rv[d][p] = 1'b0;
        end
      end
      e_werr[d] = !reset && we && (int'(waddr) >= p_depth[d]);
    end
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int a = 0; a < 8; a++) m_mem[d][a] = '0;
      end else if (write_lands(d)) begin
        m_mem[d][waddr] = merge(m_mem[d][waddr], wdata, wbe);
      end
    end
    @(posedge clk);
    #1;
    chk("a_rdata0",  rdata0_a,       e_rd[0][0]);
    chk("a_rvalid0", 32'(rvalid0_a), 32'(e_rv[0][0]));
    chk("a_rdata1",  rdata1_a,       e_rd[0][1]);
    chk("a_rvalid1", 32'(rvalid1_a), 32'(e_rv[0][1]));
    chk("a_werr",    32'(werr_a),    32'(e_werr[0]));
    chk("b_rdata0",  rdata0_b,       e_rd[1][0]);
    chk("b_rvalid0", 32'(rvalid0_b), 32'(e_rv[1][0]));
    chk("b_rdata1",  rdata1_b,       e_rd[1][1]);
    chk("b_rvalid1", 32'(rvalid1_b), 32'(e_rv[1][1]));
    chk("b_werr",    32'(werr_b),    32'(e_werr[1]));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 8; a++) m_mem[d][a] = '0;
      for (int p = 0; p < 2; p++) begin e_rd[d][p] = '0; e_rv[d][p] = 1'b0; end
      e_werr[d] = 1'b0;
    end
    idle();

    // Reset for two cycles, then check the cleared output state.
    reset = 1'b1;
    tick();
    tick();
    chk("rst_rdata0",  rdata0_a,       32'h0);
    chk("rst_rvalid0", 32'(rvalid0_a), 32'h0);
    chk("rst_werr",    32'(werr_b),    32'h0);
    idle();

    // Read back every address on both ports after reset.
    for (int i = 0; i < 8; i++) begin
      re0 = 1'b1; re1 = 1'b1; raddr0 = 3'(i); raddr1 = 3'(i);
      tick();
      chk("rst_rd_a0", rdata0_a, 32'h0);
      chk("rst_rv_a0", 32'(rvalid0_a), 32'h1);
      chk("rst_rd_b1", rdata1_b, 32'h0);
    end
    idle();

    // Full write then read.
    we = 1'b1; waddr = 3'd3; wdata = 32'hDEADBEEF; wbe = 4'hF;
    tick();
    idle(); re0 = 1'b1; raddr0 = 3'd3;
    tick();
    chk("full_wr_a", rdata0_a, 32'hDEADBEEF);
    chk("full_wr_b", rdata0_b, 32'hDEADBEEF);
    chk("full_wr_v", 32'(rvalid0_a), 32'h1);

    // Partial byte write.
    idle(); we = 1'b1; waddr = 3'd3; wdata = 32'h11223344; wbe = 4'b0101;
    tick();
    idle(); re0 = 1'b1; raddr0 = 3'd3;
    tick();
    chk("byte_en_a", rdata0_a, 32'hDE22BE44);
    chk("byte_en_b", rdata0_b, 32'hDE22BE44);

    // Same-cycle write and read of address 5.
    idle(); we = 1'b1; waddr = 3'd5; wdata = 32'hA5A5A5A5; wbe = 4'hF;
    re1 = 1'b1; raddr1 = 3'd5;
    tick();
    chk("bypass_on",  rdata1_a, 32'hA5A5A5A5);
    chk("bypass_off", rdata1_b, 32'h0);

    // Write to address 7: out of range for B only.
    idle(); we = 1'b1; waddr = 3'd7; wdata = 32'h77777777; wbe = 4'hF;
    tick();
    chk("werr_pulse_b", 32'(werr_b), 32'h1);
    chk("werr_none_a",  32'(werr_a), 32'h0);
    idle(); re0 = 1'b1; raddr0 = 3'd7;
    tick();
    chk("werr_end_b",  32'(werr_b), 32'h0);
    chk("oor_rd_b",    rdata0_b, 32'h0);
    chk("oor_rv_b",    32'(rvalid0_b), 32'h1);
    chk("inrange_rd_a", rdata0_a, 32'h77777777);

    // Write to register 0: dropped on B.
    idle(); we = 1'b1; waddr = 3'd0; wdata = 32'hFFFFFFFF; wbe = 4'hF;
    tick();
    chk("zero_werr_b", 32'(werr_b), 32'h0);
    idle(); re1 = 1'b1; raddr1 = 3'd0;
    tick();
    chk("zero_reg_b", rdata1_b, 32'h0);
    chk("reg0_a",     rdata1_a, 32'hFFFFFFFF);

    // Reset colliding with a write and a read.
    idle(); we = 1'b1; waddr = 3'd2; wdata = 32'h12345678; wbe = 4'hF;
    tick();
    reset = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 32'hCAFEF00D; wbe = 4'hF;
    re0 = 1'b1; raddr0 = 3'd2;
    tick();
    chk("rst_mid_rv", 32'(rvalid0_a), 32'h0);
    chk("rst_mid_rd", rdata0_a, 32'h0);
    idle(); re0 = 1'b1; raddr0 = 3'd2;
    tick();
    chk("rst_mid_rdback", rdata0_a, 32'h0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      reset  = ($urandom_range(0, 59) == 0);
      we     = 1'($urandom_range(0, 3) != 0);
      waddr  = 3'($urandom_range(0, 7));
      wdata  = $urandom;
      wbe    = 4'($urandom_range(0, 15));
      re0    = 1'($urandom_range(0, 3) != 0);
      re1    = 1'($urandom_range(0, 3) != 0);
      raddr0 = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
      raddr1 = ($urandom_range(0, 3) == 0) ? raddr0 : 3'($urandom_range(0, 7));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
